// File: rtl/mem_bus_arbiter_pkg.sv
// mem_arb_pkg: shared encodings for the 6502 memory bus arbiter.
//   state_t  : arbiter FSM states (IDLE -> ACCESS -> DONE -> IDLE)
//   OWN_*    : codes driven on the owner port / used for the grant winner
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DBG  = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter_arb_prio_sel.sv
// arb_prio_sel: winner select for the memory bus arbiter.
//   Fixed CPU priority; the debug unit wins once STARVE_MAX consecutive CPU
//   grants have been issued while dbg_req was pending.
// Ports:
//   clk        in  system clock (state updates on negedge)
//   n_reset    in  synchronous active-low reset
//   idle       in  arbiter is in IDLE, so a winner here becomes a grant
//   cpu_req    in  CPU request level
//   dbg_req    in  debug unit request level
//   winner     out OWN_NONE / OWN_CPU / OWN_DBG (combinational)
module arb_prio_sel
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       idle,
  input  logic       cpu_req,
  input  logic       dbg_req,
  output logic [1:0] winner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  always_comb begin
    winner = OWN_NONE;
    if (dbg_req && (!cpu_req || starve_cnt == STARVE_LIM)) begin
      winner = OWN_DBG;
    end else if (cpu_req) begin
      winner = OWN_CPU;
    end
  end

  // Counts only grant decisions taken in IDLE; any IDLE cycle without a
  // pending debug request restarts the count.
  always_ff @(negedge clk) begin
    if (!n_reset) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (!dbg_req || winner == OWN_DBG) begin
        starve_cnt <= '0;
      end else if (winner == OWN_CPU && starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single 6502 memory port between CPU and debug
// unit using level req / one-cycle ack handshakes. Sole driver of mem_*.
// Optional feature macro: MEM_ARB_WATCH_EN (CPU address watchpoint). When not
// defined, watch_hit is tied low and watch_en/watch_addr/watch_clr are unused.
// Ports:
//   clk, n_reset                  clock (negedge active), sync active-low reset
//   cpu_req/rw/addr/wdata         CPU request (rw: 1=read 0=write)
//   cpu_rdata, cpu_ack            CPU read data (held) and completion pulse
//   dbg_req/rw/addr/wdata         debug unit request
//   dbg_rdata, dbg_ack            debug read data (held) and completion pulse
//   mem_addr/wdata/rw/en          memory bus outputs, mem_rdata memory input
//   owner                         current grant: 00 none, 01 CPU, 10 DBG
//   watch_en/addr/clr, watch_hit  sticky CPU-access watchpoint
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_rw,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rw,
  output logic              mem_en,
  output logic [1:0]        owner,
  input  logic              watch_en,
  input  logic [ADDR_W-1:0] watch_addr,
  input  logic              watch_clr,
  output logic              watch_hit
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state, state_n;
  logic [3:0]        wait_cnt, wait_cnt_n;
  logic [1:0]        winner, owner_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, cpu_rdata_n, dbg_rdata_n;
  logic              mem_rw_n, mem_en_n, cpu_ack_n, dbg_ack_n;

  arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .clk     (clk),
    .n_reset (n_reset),
    .idle    (state == ST_IDLE),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .winner  (winner)
  );

  always_comb begin
    state_n     = state;
    wait_cnt_n  = wait_cnt;
    owner_n     = owner;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_rw_n    = mem_rw;
    mem_en_n    = mem_en;
    cpu_rdata_n = cpu_rdata;
    dbg_rdata_n = dbg_rdata;
    cpu_ack_n   = 1'b0;
    dbg_ack_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (winner != OWN_NONE) begin
          owner_n    = winner;
          mem_en_n   = 1'b1;
          wait_cnt_n = WAIT_INIT;
          state_n    = ST_ACCESS;
          if (winner == OWN_DBG) begin
            mem_addr_n  = dbg_addr;
            mem_rw_n    = dbg_rw;
            mem_wdata_n = dbg_wdata;
          end else begin
            mem_addr_n  = cpu_addr;
            mem_rw_n    = cpu_rw;
            mem_wdata_n = cpu_wdata;
          end
        end
      end
      ST_ACCESS: begin
        if (wait_cnt != 4'd0) begin
          wait_cnt_n = wait_cnt - 4'd1;
        end else begin
          if (mem_rw) begin
            if (owner == OWN_DBG) dbg_rdata_n = mem_rdata;
            else                  cpu_rdata_n = mem_rdata;
          end
          if (owner == OWN_DBG) dbg_ack_n = 1'b1;
          else                  cpu_ack_n = 1'b1;
          mem_en_n = 1'b0;
          mem_rw_n = 1'b1;
          state_n  = ST_DONE;
        end
      end
      ST_DONE: begin
        owner_n = OWN_NONE;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!n_reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      owner     <= OWN_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rw    <= 1'b1;
      mem_en    <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_cnt_n;
      owner     <= owner_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_rw    <= mem_rw_n;
      mem_en    <= mem_en_n;
      cpu_rdata <= cpu_rdata_n;
      dbg_rdata <= dbg_rdata_n;
      cpu_ack   <= cpu_ack_n;
      dbg_ack   <= dbg_ack_n;
    end
  end

`ifdef MEM_ARB_WATCH_EN
  logic watch_set;
  assign watch_set = (state == ST_IDLE) && (winner == OWN_CPU) && watch_en &&
                     (cpu_addr == watch_addr);

  // Set has priority over clear in the same cycle.
  always_ff @(negedge clk) begin
    if (!n_reset)       watch_hit <= 1'b0;
    else if (watch_set) watch_hit <= 1'b1;
    else if (watch_clr) watch_hit <= 1'b0;
  end
`else
  logic watch_unused;
  assign watch_unused = ^{watch_en, watch_addr, watch_clr};
  assign watch_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int W     = 1;
  localparam int SMAX  = 4;
`ifdef MEM_ARB_WATCH_EN
  localparam bit WATCH_ON = 1'b1;
`else
  localparam bit WATCH_ON = 1'b0;
`endif

  logic        clk = 1'b1;
  logic        n_reset;
  logic        cpu_req, cpu_rw, dbg_req, dbg_rw;
  logic [15:0] cpu_addr, dbg_addr, mem_addr, watch_addr;
  logic [7:0]  cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, dbg_ack, mem_rw, mem_en, watch_en, watch_clr, watch_hit;
  logic [1:0]  owner;

  // second instance with a 3-cycle access
  logic        cpu_req3, cpu_ack3, dbg_ack3, mem_rw3, mem_en3, watch_hit3;
  logic [15:0] cpu_addr3, mem_addr3;
  logic [7:0]  cpu_rdata3, dbg_rdata3, mem_wdata3, mem_rdata3;
  logic [1:0]  owner3;

  logic [7:0] bus_mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign mem_rdata  = bus_mem[mem_addr];
  assign mem_rdata3 = 8'h77;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(W), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .n_reset(n_reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_rw(dbg_rw), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rw(mem_rw), .mem_en(mem_en), .owner(owner),
    .watch_en(watch_en), .watch_addr(watch_addr), .watch_clr(watch_clr),
    .watch_hit(watch_hit)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(3), .STARVE_MAX(SMAX)) u_dut3 (
    .clk(clk), .n_reset(n_reset),
    .cpu_req(cpu_req3), .cpu_rw(1'b1), .cpu_addr(cpu_addr3), .cpu_wdata(8'h00),
    .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3),
    .dbg_req(1'b0), .dbg_rw(1'b1), .dbg_addr(16'h0000), .dbg_wdata(8'h00),
    .dbg_rdata(dbg_rdata3), .dbg_ack(dbg_ack3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .mem_rw(mem_rw3), .mem_en(mem_en3), .owner(owner3),
    .watch_en(1'b0), .watch_addr(16'h0000), .watch_clr(1'b0),
    .watch_hit(watch_hit3)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level reference: one access at a time, j = clk edges since grant.
  bit         m_busy = 1'b0;
  int         m_j = 0;
  bit         m_dbg = 1'b0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0, m_rexp = '0, exp_crd = '0, exp_drd = '0;
  logic        m_rw = 1'b1, exp_watch = 1'b0;
  int          m_starve = 0;
  bit          exp_cack, exp_dack;
  bit          hold_cpu = 1'b0, hold_dbg = 1'b0;
  bit          grant_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic decide();
    bit to_dbg;
    bit wset;
    wset = 1'b0;
    if (!n_reset) begin
      m_busy = 0; m_j = 0; m_addr = '0; m_wdata = '0; m_rw = 1'b1;
      exp_crd = '0; exp_drd = '0; m_starve = 0; exp_watch = 1'b0;
      return;
    end
    if (m_busy) begin
      m_j++;
      if (m_j == W && m_rw) begin
        if (m_dbg) exp_drd = m_rexp;
        else       exp_crd = m_rexp;
      end
      if (m_j > W + 1) m_busy = 0;
    end
    if (!m_busy) begin
      if (!dbg_req) m_starve = 0;
      if (cpu_req || dbg_req) begin
        to_dbg = dbg_req && (!cpu_req || m_starve >= SMAX);
        m_busy = 1; m_j = 0; m_dbg = to_dbg;
        m_addr  = to_dbg ? dbg_addr  : cpu_addr;
        m_rw    = to_dbg ? dbg_rw    : cpu_rw;
        m_wdata = to_dbg ? dbg_wdata : cpu_wdata;
        if (m_rw) m_rexp = ref_mem[m_addr];
        else      ref_mem[m_addr] = m_wdata;
        grant_log.push_back(to_dbg);
        if (to_dbg)       m_starve = 0;
        else if (dbg_req) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
        wset = !to_dbg && watch_en && (cpu_addr == watch_addr);
      end
    end
    if (WATCH_ON && wset)   exp_watch = 1'b1;
    else if (watch_clr)     exp_watch = 1'b0;
  endtask

  task automatic check();
    bit in_acc;
    logic [1:0] exp_own;
    in_acc   = m_busy && m_j < W;
    exp_own  = (m_busy && m_j <= W) ? (m_dbg ? OWN_DBG : OWN_CPU) : OWN_NONE;
    exp_cack = m_busy && m_j == W && !m_dbg;
    exp_dack = m_busy && m_j == W && m_dbg;
    chk("mem_en",    32'(mem_en),    32'(in_acc));
    chk("owner",     32'(owner),     32'(exp_own));
    chk("cpu_ack",   32'(cpu_ack),   32'(exp_cack));
    chk("dbg_ack",   32'(dbg_ack),   32'(exp_dack));
    chk("ack_both",  32'(cpu_ack & dbg_ack), 32'(0));
    chk("mem_rw",    32'(mem_rw),    32'(in_acc ? m_rw : 1'b1));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
    chk("dbg_rdata", 32'(dbg_rdata), 32'(exp_drd));
    chk("watch_hit", 32'(watch_hit), 32'(exp_watch));
  endtask

  task automatic step();
    decide();
    @(posedge clk);
    if (mem_en && !mem_rw) bus_mem[mem_addr] = mem_wdata;
    check();
    if (exp_cack && !hold_cpu) cpu_req = 1'b0;
    if (exp_dack && !hold_dbg) dbg_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cpu_go(input logic rw, input logic [15:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dbg_go(input logic rw, input logic [15:0] a, input logic [7:0] d);
    dbg_req = 1'b1; dbg_rw = rw; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = bus_mem[i];
    end
    bus_mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
    n_reset = 1'b0;
    cpu_req = 0; cpu_rw = 1; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_rw = 1; dbg_addr = '0; dbg_wdata = '0;
    watch_en = 0; watch_addr = '0; watch_clr = 0;
    cpu_req3 = 0; cpu_addr3 = '0;
    run(3);
    chk("rst3_mem_en", 32'(mem_en3), 32'(0));
    chk("rst3_owner",  32'(owner3),  32'(0));
    n_reset = 1'b1;
    run(2);

    // CPU read 0x1234
    cpu_go(1'b1, 16'h1234, 8'h11);
    run(5);
    chk("cpu_read_a5", 32'(cpu_rdata), 32'h0000_00A5);

    // DBG write 0x0200 <- 0x3C
    dbg_go(1'b0, 16'h0200, 8'h3C);
    run(5);
    chk("dbg_write_mem", 32'(bus_mem[16'h0200]), 32'h0000_003C);

    // both requests held: CPU x4 then DBG, repeating
    grant_log.delete();
    hold_cpu = 1; hold_dbg = 1;
    cpu_go(1'b1, 16'h0300, 8'h00);
    dbg_go(1'b1, 16'h0301, 8'h00);
    run(32);
    hold_cpu = 0; hold_dbg = 0;
    cpu_req = 0; dbg_req = 0;
    run(5);
    for (int i = 0; i < 10; i++)
      chk($sformatf("grant_order[%0d]", i), 32'(grant_log[i]), 32'((i % 5) == 4));

    // reset during ACCESS of a CPU read
    cpu_go(1'b1, 16'h1234, 8'h00);
    step();
    n_reset = 1'b0; cpu_req = 1'b0;
    step();
    chk("rst_no_ack", 32'(cpu_ack), 32'(0));
    chk("rst_owner",  32'(owner),   32'(0));
    n_reset = 1'b1;
    step();
    cpu_go(1'b1, 16'h0200, 8'h00);
    run(5);
    chk("after_rst_read", 32'(cpu_rdata), 32'h0000_003C);

    // request dropped right after grant still completes
    cpu_go(1'b0, 16'h0205, 8'h99);
    step();
    cpu_req = 1'b0;
    run(4);
    chk("drop_write_mem", 32'(bus_mem[16'h0205]), 32'h0000_0099);

    // watchpoint
    watch_en = 1; watch_addr = 16'hFFFC;
    cpu_go(1'b1, 16'hFFFC, 8'h00);
    run(6);
    chk("watch_set", 32'(watch_hit), 32'(WATCH_ON));
    watch_clr = 1; step(); watch_clr = 0;
    dbg_go(1'b1, 16'hFFFC, 8'h00);
    run(5);
    chk("watch_dbg", 32'(watch_hit), 32'(0));
    watch_clr = 1;
    cpu_go(1'b1, 16'hFFFC, 8'h00);
    step();
    watch_clr = 0;
    run(4);
    chk("watch_set_beats_clr", 32'(watch_hit), 32'(WATCH_ON));
    watch_en = 0;

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      if (!cpu_req && $urandom_range(0, 2) == 0)
        cpu_go(1'($urandom_range(0, 1)), 16'h0200 + 16'($urandom_range(0, 7)), 8'($urandom));
      if (!dbg_req && $urandom_range(0, 3) == 0)
        dbg_go(1'($urandom_range(0, 1)), 16'h0200 + 16'($urandom_range(0, 7)), 8'($urandom));
      watch_en   = 1'($urandom_range(0, 1));
      watch_addr = 16'h0200 + 16'($urandom_range(0, 7));
      watch_clr  = ($urandom_range(0, 7) == 0);
      step();
    end
    watch_clr = 0;
    run(12);
    cpu_req = 0; dbg_req = 0;
    run(4);

    // WAIT_CYCLES=3 instance: CPU read 0x00FF
    cpu_req3 = 1'b1; cpu_addr3 = 16'h00FF;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      chk($sformatf("w3_en[%0d]", j),  32'(mem_en3),  32'(1));
      chk($sformatf("w3_ack[%0d]", j), 32'(cpu_ack3), 32'(0));
      chk($sformatf("w3_own[%0d]", j), 32'(owner3),   32'(1));
      chk($sformatf("w3_addr[%0d]", j), 32'(mem_addr3), 32'h0000_00FF);
    end
    @(posedge clk);
    cpu_req3 = 1'b0;
    chk("w3_en_end", 32'(mem_en3),    32'(0));
    chk("w3_ack",    32'(cpu_ack3),   32'(1));
    chk("w3_rdata",  32'(cpu_rdata3), 32'h0000_0077);
    @(posedge clk);
    chk("w3_ack_off", 32'(cpu_ack3), 32'(0));
    chk("w3_own_off", 32'(owner3),   32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
